// File: rtl/acs_pm_bank_if.sv
// Step-input / decision-output bundle between the branch-metric bank,
// the ACS path-metric bank and the traceback memory.
interface acs_pm_bank_if #(
  parameter int NUM_STATES = 64,
  parameter int M          = $clog2(NUM_STATES)
);
  logic                    in_valid;
  logic                    frame_start;
  logic [2*NUM_STATES-1:0] bm0_flat;
  logic [2*NUM_STATES-1:0] bm1_flat;
  logic                    dec_valid;
  logic [NUM_STATES-1:0]   dec;
  logic [M-1:0]            best_state;
  logic                    norm_pulse;

  modport master (
    output in_valid, frame_start, bm0_flat, bm1_flat,
    input  dec_valid, dec, best_state, norm_pulse
  );

  modport slave (
    input  in_valid, frame_start, bm0_flat, bm1_flat,
    output dec_valid, dec, best_state, norm_pulse
  );
endinterface

// File: rtl/acs_pm_bank.sv
// Parallel add-compare-select over all trellis states with a registered
// path-metric store, MSB-based normalisation and best-state argmin.
module acs_pm_bank #(
  parameter int              NUM_STATES = 64,
  parameter int              PM_W       = 8,
  parameter logic [PM_W-1:0] INIT_PM    = 8'd64
) (
  input  logic         clk,
  input  logic         rst_n,
  acs_pm_bank_if.slave bus
);
  localparam int M  = $clog2(NUM_STATES);
  localparam int CW = PM_W + 1;
  localparam logic [CW-1:0] NORM_SUB = {2'b01, {(PM_W-1){1'b0}}};

  logic [PM_W-1:0]       pm_q   [NUM_STATES];
  logic [PM_W-1:0]       pm_d   [NUM_STATES];
  logic [PM_W-1:0]       pm_src [NUM_STATES];
  logic [PM_W-1:0]       pm_new [NUM_STATES];
  logic [NUM_STATES-1:0] dec_q, dec_d, dec_new;
  logic [M-1:0]          best_q, best_d, best_new;
  logic                  dec_valid_q, dec_valid_d;
  logic                  norm_q, norm_d;
  logic                  norm_now;
  logic [PM_W-1:0]       best_pm;

  // A frame start substitutes the initial metrics for the stored ones so
  // that the same step can already run ACS on a fresh trellis.
  always_comb begin
    norm_now = 1'b1;
    for (int s = 0; s < NUM_STATES; s++) begin
      if (bus.frame_start) begin
        pm_src[s] = (s == 0) ? '0 : INIT_PM;
      end else begin
        pm_src[s] = pm_q[s];
      end
      norm_now = norm_now & pm_src[s][PM_W-1];
    end
  end

  always_comb begin : acs_comb
    int p0;
    logic [CW-1:0] c0;
    logic [CW-1:0] c1;
    p0      = 0;
    c0      = '0;
    c1      = '0;
    dec_new = '0;
    for (int s = 0; s < NUM_STATES; s++) begin
      p0 = (2 * s) % NUM_STATES;
      c0 = CW'(pm_src[p0])     + CW'(bus.bm0_flat[2*s +: 2]);
      c1 = CW'(pm_src[p0 + 1]) + CW'(bus.bm1_flat[2*s +: 2]);
      if (norm_now) begin
        c0 = c0 - NORM_SUB;
        c1 = c1 - NORM_SUB;
      end
      dec_new[s] = (c1 < c0);
      pm_new[s]  = dec_new[s] ? c1[PM_W-1:0] : c0[PM_W-1:0];
    end
  end

  // Strict less-than keeps the lowest index among equal metrics.
  always_comb begin
    best_new = '0;
    best_pm  = pm_new[0];
    for (int s = 1; s < NUM_STATES; s++) begin
      if (pm_new[s] < best_pm) begin
        best_pm  = pm_new[s];
        best_new = M'(s);
      end
    end
  end

  always_comb begin
    pm_d        = pm_q;
    dec_d       = dec_q;
    best_d      = best_q;
    dec_valid_d = 1'b0;
    norm_d      = 1'b0;
    if (bus.in_valid) begin
      pm_d        = pm_new;
      dec_d       = dec_new;
      best_d      = best_new;
      dec_valid_d = 1'b1;
      norm_d      = norm_now;
    end else if (bus.frame_start) begin
      pm_d = pm_src;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_q[s] <= (s == 0) ? '0 : INIT_PM;
      end
      dec_q       <= '0;
      best_q      <= '0;
      dec_valid_q <= 1'b0;
      norm_q      <= 1'b0;
    end else begin
      pm_q        <= pm_d;
      dec_q       <= dec_d;
      best_q      <= best_d;
      dec_valid_q <= dec_valid_d;
      norm_q      <= norm_d;
    end
  end

  assign bus.dec_valid  = dec_valid_q;
  assign bus.dec        = dec_q;
  assign bus.best_state = best_q;
  assign bus.norm_pulse = norm_q;
endmodule

// File: tb/tb_acs_pm_bank.sv
// Directed bench for acs_pm_bank: hand-computed path metrics, decisions,
// normalisation, gaps, frame restarts and asynchronous reset.
module tb_acs_pm_bank;
  localparam int N = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [2*N-1:0] bm0, bm1;

  acs_pm_bank_if #(.NUM_STATES(N)) bus ();

  acs_pm_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [2*N-1:0] fill(input logic [1:0] v);
    logic [2*N-1:0] r;
    for (int i = 0; i < N; i++) r[2*i +: 2] = v;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_step(input logic v, input logic fs);
    bus.in_valid    = v;
    bus.frame_start = fs;
    bus.bm0_flat    = bm0;
    bus.bm1_flat    = bm1;
    @(posedge clk);
    #1;
    bus.in_valid    = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic check_first_step(input string tag);
    chk({tag, "_valid"}, bus.dec_valid, 1);
    chk({tag, "_pm0"}, dut.pm_q[0], 0);
    chk({tag, "_pm1"}, dut.pm_q[1], 64);
    chk({tag, "_pm32"}, dut.pm_q[32], 0);
    chk({tag, "_dec"}, bus.dec, 0);
    chk({tag, "_best"}, bus.best_state, 0);
    chk({tag, "_norm"}, bus.norm_pulse, 0);
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.frame_start = 1'b0;
    bus.bm0_flat    = '0;
    bus.bm1_flat    = '0;

    #12;
    chk("rst_valid", bus.dec_valid, 0);
    chk("rst_dec", bus.dec, 0);
    chk("rst_best", bus.best_state, 0);
    chk("rst_norm", bus.norm_pulse, 0);
    chk("rst_pm0", dut.pm_q[0], 0);
    chk("rst_pm5", dut.pm_q[5], 64);
    @(negedge clk);
    rst_n = 1'b1;

    // Step 1 from init: zeros only reach states 0 and 32.
    bm0 = fill(2'd0);
    bm1 = fill(2'd2);
    do_step(1'b1, 1'b0);
    check_first_step("step1");
    do_step(1'b0, 1'b0);
    chk("single_valid", bus.dec_valid, 0);

    // Zero-cost paths spread until every state is 0 after six steps.
    for (int k = 2; k <= 5; k++) do_step(1'b1, 1'b0);
    chk("step5_pm1", dut.pm_q[1], 64);
    chk("step5_pm2", dut.pm_q[2], 0);
    do_step(1'b1, 1'b0);
    chk("step6_pm1", dut.pm_q[1], 0);
    chk("step6_pm63", dut.pm_q[63], 0);

    // Uniform metric 1 on both branches: all ties, all metrics reach 5.
    bm0 = fill(2'd1);
    bm1 = fill(2'd1);
    for (int k = 0; k < 5; k++) do_step(1'b1, 1'b0);
    chk("ones_pm0", dut.pm_q[0], 5);
    chk("ones_pm1", dut.pm_q[1], 5);
    chk("ones_dec", bus.dec, 0);

    // Tie at state 0 with PM[0] = PM[1] = 5.
    bm0 = fill(2'd2);
    bm1 = fill(2'd2);
    bm0[1:0] = 2'd1;
    bm1[1:0] = 2'd1;
    do_step(1'b1, 1'b0);
    chk("tie_pm0", dut.pm_q[0], 6);
    chk("tie_pm1", dut.pm_q[1], 7);
    chk("tie_dec", bus.dec, 0);

    // Path-1 selection at state 32: 6+2 versus 7+0.
    bm0 = fill(2'd0);
    bm1 = fill(2'd0);
    bm0[65:64] = 2'd2;
    do_step(1'b1, 1'b0);
    chk("p1_pm32", dut.pm_q[32], 7);
    chk("p1_pm0", dut.pm_q[0], 6);
    chk("p1_dec", bus.dec, 64'h0000_0001_0000_0000);
    chk("p1_valid", bus.dec_valid, 1);

    // Gap of two idle cycles: everything holds, dec_valid low.
    do_step(1'b0, 1'b0);
    chk("gap1_valid", bus.dec_valid, 0);
    do_step(1'b0, 1'b0);
    chk("gap2_valid", bus.dec_valid, 0);
    chk("gap2_dec", bus.dec, 64'h0000_0001_0000_0000);
    chk("gap2_pm32", dut.pm_q[32], 7);
    bm0 = fill(2'd0);
    do_step(1'b1, 1'b0);
    chk("gap_end_valid", bus.dec_valid, 1);
    chk("gap_end_pm32", dut.pm_q[32], 6);
    chk("gap_end_dec", bus.dec, 0);

    // Mid-frame restart: ACS runs on init metrics, not the stored 6/7.
    bm0 = fill(2'd0);
    bm1 = fill(2'd2);
    bm0[65:64] = 2'd2;
    bm1[65:64] = 2'd0;
    do_step(1'b1, 1'b1);
    chk("fs_pm0", dut.pm_q[0], 0);
    chk("fs_pm1", dut.pm_q[1], 64);
    chk("fs_pm16", dut.pm_q[16], 64);
    chk("fs_pm32", dut.pm_q[32], 2);
    chk("fs_dec", bus.dec, 0);
    chk("fs_valid", bus.dec_valid, 1);

    // Frame start alone reloads the init metrics without an output step.
    do_step(1'b0, 1'b1);
    chk("fso_pm32", dut.pm_q[32], 64);
    chk("fso_pm0", dut.pm_q[0], 0);
    chk("fso_valid", bus.dec_valid, 0);

    // All-2 metrics: every state is 2k once k >= 6, so 128 at step 64.
    bm0 = fill(2'd2);
    bm1 = fill(2'd2);
    for (int k = 0; k < 64; k++) do_step(1'b1, 1'b0);
    chk("pre_norm_pm0", dut.pm_q[0], 128);
    chk("pre_norm_pm63", dut.pm_q[63], 128);
    chk("pre_norm_pulse", bus.norm_pulse, 0);

    bm0[11:10] = 2'd1;
    bm1[11:10] = 2'd1;
    do_step(1'b1, 1'b0);
    chk("norm_pulse", bus.norm_pulse, 1);
    chk("norm_pm0", dut.pm_q[0], 2);
    chk("norm_pm5", dut.pm_q[5], 1);
    chk("norm_pm63", dut.pm_q[63], 2);
    chk("norm_best", bus.best_state, 5);

    // State 5 feeds successors 2 and 34 via path 1; lowest index wins.
    bm0 = fill(2'd0);
    bm1 = fill(2'd0);
    do_step(1'b1, 1'b0);
    chk("post_norm_pulse", bus.norm_pulse, 0);
    chk("post_pm2", dut.pm_q[2], 1);
    chk("post_pm34", dut.pm_q[34], 1);
    chk("post_pm5", dut.pm_q[5], 2);
    chk("post_dec", bus.dec, 64'h0000_0004_0000_0004);
    chk("post_best", bus.best_state, 2);
    do_step(1'b0, 1'b0);
    chk("hold_best", bus.best_state, 2);
    chk("hold_norm", bus.norm_pulse, 0);

    // Asynchronous reset between edges during a burst.
    bus.in_valid = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.dec_valid, 0);
    chk("arst_dec", bus.dec, 0);
    chk("arst_best", bus.best_state, 0);
    chk("arst_pm0", dut.pm_q[0], 0);
    chk("arst_pm5", dut.pm_q[5], 64);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bm0 = fill(2'd0);
    bm1 = fill(2'd2);
    do_step(1'b1, 1'b0);
    check_first_step("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/acs_pm_bank.md
# acs_pm_bank

Add-compare-select and path-metric store for the 64-state, rate-1/2, hard-decision Viterbi decoder. Sits directly downstream of the branch-metric bank: it consumes the 2-bit path_0/path_1 branch metrics of every state once per received pair. It updates all path metrics in parallel and emits one survivor-decision bit per state to the traceback memory, plus the index of the current best state.

## Interface
Parameters:
- NUM_STATES, 64, trellis states; power of two, M = log2(NUM_STATES)
- PM_W, 8, path-metric width in bits (unsigned)
- INIT_PM, 8'd64, reset/start metric of every state except state 0; state 0 starts at 0

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  branch metrics valid this cycle; one trellis step per accepted cycle
- frame_start  input  1  re-initialise path metrics at start of a new frame
- bm0_flat  input  2*NUM_STATES  path_0 metric of state s at bits [2s+1:2s], value 0..2
- bm1_flat  input  2*NUM_STATES  path_1 metric of state s at bits [2s+1:2s], value 0..2
- dec_valid  output  1  dec and best_state valid
- dec  output  NUM_STATES  survivor decision per state: 1 = path_1 chosen
- best_state  output  M  index of minimum path metric after this step
- norm_pulse  output  1  normalisation applied in this step (debug)

## Operation
- Trellis convention:
  - successor s has predecessors p0 = (2s) mod NUM_STATES and p1 = p0 + 1
  - bm0[s] is the metric on branch p0->s; bm1[s] is the metric on branch p1->s
- ACS per state on an accepted step:
  - c0 = PM[p0] + bm0[s], c1 = PM[p1] + bm1[s], computed at PM_W+1 bits
  - PM'[s] = min(c0, c1); dec[s] = (c1 < c0)
  - on a tie, path 0 wins and dec[s] = 0
- Normalisation:
  - if every PM register has its MSB set before the step, subtract 2^(PM_W-1) from every c0/c1 before select, and pulse norm_pulse with that step
  - adds cannot overflow PM_W bits: spread is bounded below 2^(PM_W-1) for the given defaults
- best_state:
  - argmin over the new PM' values
  - on equal metrics, the lowest index wins
- Initialisation (reset, or frame_start):
  - PM[0] = 0, PM[s != 0] = INIT_PM
- frame_start with in_valid: this step's ACS uses the initialisation values as PM, not the registers.
- frame_start without in_valid: registers load initialisation values; no outputs generated.
- in_valid low: PM registers hold; dec, best_state hold their last values; dec_valid = 0.
- No back-pressure: a step is accepted whenever in_valid = 1.

## Timing
- Latency 1: step inputs at edge n produce PM, dec, best_state, dec_valid, norm_pulse registered at edge n+1.
- Throughput: one step per clock, back-to-back in_valid supported.
- Reset values, all asserted asynchronously:
  - PM as initialisation
  - dec = 0, best_state = 0
  - dec_valid = 0, norm_pulse = 0
- Reset mid-frame discards all metrics; the first post-reset step behaves as frame_start.
- dec_valid and norm_pulse are single-cycle per step; they are never asserted without a preceding in_valid.
- All ACS, normalisation and argmin logic is single-cycle combinational between PM registers and outputs; no internal pipeline.

## Test plan
- Reset then one step, all bm0 = 0, bm1 = 2:
  - dec_valid one cycle later
  - PM[0] = 0, PM[1] = 64, PM[32] = 0
  - dec = all 0, best_state = 0
- Tie check, state 0:
  - force PM[0] = PM[1] = 5 by a preceding step, then bm0[0] = bm1[0] = 1
  - expect PM[0] = 6, dec[0] = 0
- Path-1 selection:
  - after init, step with bm0[32] = 2 and bm1[32] = 0 (p0 = 0, p1 = 1)
  - expect PM[32] = 2, dec[32] = 0, since 0+2 < 64+0
  - repeat with PM[1] preloaded to 0 via earlier steps: expect dec[32] = 1
- Normalisation:
  - drive steps of all-2 metrics until every PM >= 128
  - the next step asserts norm_pulse and every new PM equals old min + 2 - 128
  - best_state unchanged vs. un-normalised model
- Gaps and frame_start:
  - in_valid pattern 1,0,0,1: outputs hold through the gap, dec_valid = 1,0,0,1
  - frame_start + in_valid mid-frame restarts from init metrics, matching a fresh-reset reference model
- Async reset asserted between clock edges during a burst:
  - outputs zero immediately
  - next accepted step matches the first post-reset step of a random 1000-step run checked against a golden C Viterbi model
